// File: rtl/huffman_codebook_gen.sv
// Iterative Huffman tree builder with canonical code assignment.
// The tree is built with one merge per cycle, then codes are swept with one symbol per cycle.
module huffman_codebook_gen #(
    parameter int NSYM    = 4,
    parameter int FREQ_W  = 8,
    parameter int MAX_LEN = 7,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    start,
    input  logic [NSYM*FREQ_W-1:0]  freq_in,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NSYM*LEN_W-1:0]   code_len,
    output logic [NSYM*MAX_LEN-1:0] code
);

    localparam int IDX_W = $clog2(NSYM);
    localparam int WW    = FREQ_W + IDX_W;
    localparam int NW    = MAX_LEN + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MERGE,
        S_CANON,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WW-1:0]      weight_q [NSYM];
    logic [WW-1:0]      weight_d [NSYM];
    logic [NSYM-1:0]    active_q, active_d;
    logic [IDX_W-1:0]   group_q  [NSYM];
    logic [IDX_W-1:0]   group_d  [NSYM];
    logic [LEN_W-1:0]   len_q    [NSYM];
    logic [LEN_W-1:0]   len_d    [NSYM];
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   pass_q, pass_d;
    logic [IDX_W-1:0]   sym_q, sym_d;
    logic [NW-1:0]      nxt_q, nxt_d;
    logic [LEN_W-1:0]   clen_q   [NSYM];
    logic [LEN_W-1:0]   clen_d   [NSYM];
    logic [MAX_LEN-1:0] code_q   [NSYM];
    logic [MAX_LEN-1:0] code_d   [NSYM];
    logic               err_q, err_d;

    // Two-smallest search over the active entries; strict compare keeps the lowest index on ties.
    int unsigned        act_cnt;
    logic [IDX_W-1:0]   m1, m2;
    logic [WW-1:0]      w1, w2;
    logic               f1, f2;

    always_comb begin
        act_cnt = 0;
        m1 = '0;
        m2 = '0;
        w1 = '0;
        w2 = '0;
        f1 = 1'b0;
        f2 = 1'b0;
        for (int unsigned j = 0; j < NSYM; j++) begin
            if (active_q[j]) begin
                act_cnt = act_cnt + 1;
                if (!f1 || weight_q[j] < w1) begin
                    m1 = IDX_W'(j);
                    w1 = weight_q[j];
                    f1 = 1'b1;
                end
            end
        end
        for (int unsigned j = 0; j < NSYM; j++) begin
            if (active_q[j] && (IDX_W'(j) != m1) && (!f2 || weight_q[j] < w2)) begin
                m2 = IDX_W'(j);
                w2 = weight_q[j];
                f2 = 1'b1;
            end
        end
    end

    logic          hit;
    logic [NW-1:0] nxt_inc;

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        active_d = active_q;
        group_d  = group_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        pass_d   = pass_q;
        sym_d    = sym_q;
        nxt_d    = nxt_q;
        clen_d   = clen_q;
        code_d   = code_q;
        err_d    = err_q;
        hit      = 1'b0;
        nxt_inc  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int unsigned j = 0; j < NSYM; j++) begin
                        weight_d[j] = WW'(freq_in[j*FREQ_W +: FREQ_W]);
                        active_d[j] = |freq_in[j*FREQ_W +: FREQ_W];
                        group_d[j]  = IDX_W'(j);
                        len_d[j]    = '0;
                        clen_d[j]   = '0;
                        code_d[j]   = '0;
                    end
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    pass_d  = LEN_W'(1);
                    sym_d   = '0;
                    nxt_d   = '0;
                    state_d = S_MERGE;
                end
            end

            S_MERGE: begin
                if (act_cnt >= 2) begin
                    weight_d[m1] = w1 + w2;
                    active_d[m2] = 1'b0;
                    for (int unsigned j = 0; j < NSYM; j++) begin
                        if (group_q[j] == m1 || group_q[j] == m2) begin
                            group_d[j] = m1;
                            if (len_q[j] == LEN_W'(MAX_LEN))
                                ovf_d = 1'b1;
                            else
                                len_d[j] = len_q[j] + 1'b1;
                        end
                    end
                end else begin
                    // A lone nonzero symbol still needs a one-bit code.
                    if (act_cnt == 1 && len_q[m1] == '0)
                        len_d[m1] = LEN_W'(1);
                    state_d = S_CANON;
                end
            end

            S_CANON: begin
                hit     = (len_q[sym_q] == pass_q);
                nxt_inc = nxt_q + NW'(hit);
                if (hit)
                    code_d[sym_q] = nxt_q[MAX_LEN-1:0];
                if (sym_q == IDX_W'(NSYM - 1)) begin
                    sym_d  = '0;
                    nxt_d  = nxt_inc << 1;
                    pass_d = pass_q + 1'b1;
                    if (pass_q == LEN_W'(MAX_LEN)) begin
                        state_d = S_DONE;
                        err_d   = ovf_q;
                        for (int unsigned j = 0; j < NSYM; j++) begin
                            clen_d[j] = ovf_q ? '0 : len_q[j];
                            if (ovf_q)
                                code_d[j] = '0;
                        end
                    end
                end else begin
                    sym_d = sym_q + 1'b1;
                    nxt_d = nxt_inc;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            active_q <= '0;
            ovf_q    <= 1'b0;
            pass_q   <= '0;
            sym_q    <= '0;
            nxt_q    <= '0;
            err_q    <= 1'b0;
            for (int unsigned j = 0; j < NSYM; j++) begin
                weight_q[j] <= '0;
                group_q[j]  <= '0;
                len_q[j]    <= '0;
                clen_q[j]   <= '0;
                code_q[j]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            ovf_q    <= ovf_d;
            pass_q   <= pass_d;
            sym_q    <= sym_d;
            nxt_q    <= nxt_d;
            err_q    <= err_d;
            for (int unsigned j = 0; j < NSYM; j++) begin
                weight_q[j] <= weight_d[j];
                group_q[j]  <= group_d[j];
                len_q[j]    <= len_d[j];
                clen_q[j]   <= clen_d[j];
                code_q[j]   <= code_d[j];
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

    for (genvar g = 0; g < NSYM; g++) begin : g_pack
        assign code_len[g*LEN_W +: LEN_W]   = clen_q[g];
        assign code[g*MAX_LEN +: MAX_LEN]   = code_q[g];
    end

endmodule

// File: tb/tb_huffman_codebook_gen.sv
// Directed bench for huffman_codebook_gen: a default instance and an NSYM=8, MAX_LEN=3 instance.
module tb_huffman_codebook_gen;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [31:0] freq_in;
    logic        busy, done, err;
    logic [11:0] code_len;
    logic [27:0] code;

    logic        o_start;
    logic [63:0] o_freq;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_code_len;
    logic [23:0] o_code;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] F_BASIC = {8'd61, 8'd43, 8'd12, 8'd10};
    localparam logic [11:0] L_BASIC = {3'd1, 3'd2, 3'd3, 3'd3};
    localparam logic [27:0] C_BASIC = {7'b0000000, 7'b0000010, 7'b0000111, 7'b0000110};
    localparam logic [31:0] F_TIES  = {8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [11:0] L_TIES  = {3'd2, 3'd2, 3'd2, 3'd2};
    localparam logic [27:0] C_TIES  = {7'd3, 7'd2, 7'd1, 7'd0};
    localparam logic [63:0] F_FIB   = {8'd21, 8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1, 8'd1};
    localparam logic [63:0] F_FLAT  = {8{8'd1}};
    localparam logic [23:0] C_FLAT  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    huffman_codebook_gen dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .freq_in  (freq_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .code_len (code_len),
        .code     (code)
    );

    huffman_codebook_gen #(
        .NSYM    (8),
        .FREQ_W  (8),
        .MAX_LEN (3)
    ) dut_ovf (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (o_start),
        .freq_in  (o_freq),
        .busy     (o_busy),
        .done     (o_done),
        .err      (o_err),
        .code_len (o_code_len),
        .code     (o_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulses start on the chosen instance and returns cycles from the sampling edge to done.
    task automatic run_build(input bit sel, input logic [63:0] f, output int lat);
        @(negedge CLK);
        if (sel) begin
            o_freq  = f;
            o_start = 1'b1;
        end else begin
            freq_in = f[31:0];
            start   = 1'b1;
        end
        @(posedge CLK);
        #1;
        start   = 1'b0;
        o_start = 1'b0;
        lat = 0;
        while (((sel ? o_done : done) !== 1'b1) && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        start = 1'b0;
        o_start = 1'b0;
        freq_in = '0;
        o_freq = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (code_len !== 12'h0) begin errors++; $display("FAIL reset_len got %h want 0", code_len); end
        checks++; if (code !== 28'h0) begin errors++; $display("FAIL reset_code got %h want 0", code); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_obusy got %b want 0", o_busy); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_build(1'b0, {32'h0, F_BASIC}, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
        checks++; if (code_len !== L_BASIC) begin errors++; $display("FAIL basic_len got %h want %h", code_len, L_BASIC); end
        checks++; if (code !== C_BASIC) begin errors++; $display("FAIL basic_code got %h want %h", code, C_BASIC); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
        @(posedge CLK);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy); end
        checks++; if (code_len !== L_BASIC) begin errors++; $display("FAIL basic_len_hold got %h want %h", code_len, L_BASIC); end
    endtask

    task automatic test_ties();
        int lat;
        run_build(1'b0, {32'h0, F_TIES}, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL ties_latency got %0d want 32", lat); end
        checks++; if (code_len !== L_TIES) begin errors++; $display("FAIL ties_len got %h want %h", code_len, L_TIES); end
        checks++; if (code !== C_TIES) begin errors++; $display("FAIL ties_code got %h want %h", code, C_TIES); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single_empty();
        int lat;
        run_build(1'b0, {32'h0, 8'd0, 8'd0, 8'd5, 8'd0}, lat);
        checks++; if (lat !== 29) begin errors++; $display("FAIL single_latency got %0d want 29", lat); end
        checks++; if (code_len !== {3'd0, 3'd0, 3'd1, 3'd0}) begin errors++; $display("FAIL single_len got %h want 008", code_len); end
        checks++; if (code !== 28'h0) begin errors++; $display("FAIL single_code got %h want 0", code); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
        @(posedge CLK);
        #1;
        run_build(1'b0, 64'h0, lat);
        checks++; if (lat !== 29) begin errors++; $display("FAIL empty_latency got %0d want 29", lat); end
        checks++; if (code_len !== 12'h0) begin errors++; $display("FAIL empty_len got %h want 0", code_len); end
        checks++; if (code !== 28'h0) begin errors++; $display("FAIL empty_code got %h want 0", code); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_err got %b want 0", err); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_overflow();
        int lat;
        run_build(1'b1, F_FIB, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL ovf_latency got %0d want 32", lat); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", o_err); end
        checks++; if (o_code_len !== 16'h0) begin errors++; $display("FAIL ovf_len got %h want 0", o_code_len); end
        checks++; if (o_code !== 24'h0) begin errors++; $display("FAIL ovf_code got %h want 0", o_code); end
        @(posedge CLK);
        #1;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ovf_err_hold got %b want 1", o_err); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL ovf_done_pulse got %b want 0", o_done); end
    endtask

    task automatic test_restart_and_reset();
        int lat;
        @(negedge CLK);
        freq_in = F_BASIC;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        freq_in = F_TIES;
        lat = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL restart_latency got %0d want 32", lat); end
        checks++; if (code_len !== L_BASIC) begin errors++; $display("FAIL restart_len got %h want %h", code_len, L_BASIC); end
        checks++; if (code !== C_BASIC) begin errors++; $display("FAIL restart_code got %h want %h", code, C_BASIC); end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        freq_in = F_TIES;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(posedge CLK);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL merge_busy got %b want 1", busy); end
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", busy); end
        checks++; if (code_len !== 12'h0 || code !== 28'h0 || err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_outputs got len %h code %h err %b done %b want all 0", code_len, code, err, done);
        end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL async_rst_oerr got %b want 0", o_err); end
        @(negedge CLK);
        nRST = 1'b1;
        run_build(1'b0, {32'h0, F_TIES}, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL post_rst_latency got %0d want 32", lat); end
        checks++; if (code_len !== L_TIES) begin errors++; $display("FAIL post_rst_len got %h want %h", code_len, L_TIES); end
        checks++; if (code !== C_TIES) begin errors++; $display("FAIL post_rst_code got %h want %h", code, C_TIES); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        run_build(1'b0, {32'h0, F_BASIC}, lat);
        @(posedge CLK);
        #1;
        run_build(1'b0, {32'h0, F_TIES}, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency got %0d want 32", lat); end
        checks++; if (code_len !== L_TIES) begin errors++; $display("FAIL b2b_len got %h want %h", code_len, L_TIES); end
        checks++; if (code !== C_TIES) begin errors++; $display("FAIL b2b_code got %h want %h", code, C_TIES); end

        run_build(1'b1, F_FIB, lat);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL b2b_ovf_err got %b want 1", o_err); end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        o_freq = F_FLAT;
        o_start = 1'b1;
        @(posedge CLK);
        #1;
        o_start = 1'b0;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL b2b_err_cleared got %b want 0", o_err); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_obusy got %b want 1", o_busy); end
        lat = 0;
        while (o_done !== 1'b1 && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL flat_latency got %0d want 32", lat); end
        checks++; if (o_code_len !== 16'hFFFF) begin errors++; $display("FAIL flat_len got %h want ffff", o_code_len); end
        checks++; if (o_code !== C_FLAT) begin errors++; $display("FAIL flat_code got %h want %h", o_code, C_FLAT); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL flat_err got %b want 0", o_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_single_empty();
        test_overflow();
        test_restart_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
